imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, meaning the number of instruction-memory words.
REQ-002 The block SHALL have parameter IW, default 13, meaning the instruction width in bits.
REQ-003 The block SHALL have parameter AW, default 5, meaning the address width (log2 DEPTH).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have these ports, one per line:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins a load
- run_len  in  8  ce cycles to run, sampled on start; 0 means unlimited
- stop  in  1  ends RUN
- in_valid  in  1  upstream word valid
- in_data  in  IW  instruction word
- in_last  in  1  final word of the program
- in_ready  out  1  loader accepts a word
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  AW  write address
- imem_wdata  out  IW  write data
- proc_hold  out  1  holds the processor in reset
- ce  out  1  processor clock enable
- busy  out  1  in LOAD or RUN
- done  out  1  in HALT
- err_trunc  out  1  sticky: DEPTH words accepted without in_last
- words_loaded  out  AW+1  count of accepted words

Function
REQ-006 The FSM SHALL have states IDLE, LOAD, RUN and HALT.
REQ-007 In IDLE, in_ready=0, ce=0 and proc_hold=1; start SHALL move the FSM to LOAD, clear words_loaded and err_trunc, and latch run_len.
REQ-008 In LOAD, in_ready SHALL be 1, and a word is accepted on any cycle where in_valid and in_ready are both 1.
REQ-009 An accepted word SHALL produce imem_we=1, imem_addr=words_loaded (pre-increment) and imem_wdata=in_data, all registered and visible the cycle after acceptance; imem_we SHALL otherwise be 0.
REQ-010 words_loaded SHALL increment by 1 per accepted word and SHALL saturate at DEPTH.
REQ-011 Accepting a word with in_last=1, or accepting word index DEPTH-1, SHALL move the FSM to RUN on the next edge; in_ready SHALL be 0 from that edge onward.
REQ-012 Accepting word index DEPTH-1 with in_last=0 SHALL set err_trunc; further upstream words are not accepted.
REQ-013 In RUN, proc_hold SHALL be 0 and ce SHALL be 1, and an 8-bit run counter SHALL count ce cycles.
REQ-014 RUN SHALL end after exactly run_len ce-high cycles (run_len≠0) or on stop, whichever comes first, moving to HALT.
REQ-015 With run_len=0, RUN SHALL end only on stop.
REQ-016 In HALT, ce=0, proc_hold=0 (processor state preserved) and done=1; start SHALL move the FSM to LOAD (same actions as REQ-007).
REQ-017 start SHALL be ignored in LOAD and RUN; stop SHALL be ignored outside RUN; start and stop together in RUN SHALL resolve as stop.
REQ-018 in_valid outside LOAD SHALL be ignored, with no write and no count change.
REQ-019 busy SHALL equal (state==LOAD || state==RUN).

Reset
REQ-020 Asserting reset SHALL asynchronously force state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, proc_hold=1, ce=0, busy=0, done=0, err_trunc=0, words_loaded=0 and the run counter to 0.
REQ-021 Reset asserted mid-LOAD or mid-RUN SHALL abort the operation, and no imem_we pulse SHALL follow the release of reset.

Structure
REQ-022 The state enumeration and the DEPTH/IW/AW defaults SHALL live in a shared package, loader_pkg.
REQ-023 The run counter SHALL be a sub-module, run_timer, with load, enable, terminal-count and unlimited-mode inputs/outputs.

Verification
REQ-024 Load 3 words (0x0A1, 0x1B2, 0x1FFF with in_last), run_len=4 -> writes at addr 0,1,2 one cycle after each handshake; words_loaded=3; ce high exactly 4 cycles; then done=1.
REQ-025 Load 32 words with in_last never set -> 32 writes at addr 0..31; err_trunc=1; in_ready=0 after the 32nd word; FSM enters RUN.
REQ-026 in_valid toggled every other cycle during LOAD -> writes only on handshake cycles; addresses contiguous.
REQ-027 run_len=0 and stop pulsed after 10 cycles -> ce high exactly 10 cycles; done=1; start together with stop in RUN -> stop wins, FSM enters HALT.
REQ-028 reset asserted after the 2nd word of a load -> all outputs at reset values immediately; no write after release; the next start reloads from addr 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and default sizing for the instruction-memory loader.
package loader_pkg;

  localparam int unsigned DEF_DEPTH = 32;
  localparam int unsigned DEF_IW    = 13;
  localparam int unsigned DEF_AW    = 5;
  localparam int unsigned RUN_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Upstream instruction-word stream: valid/ready handshake with end-of-program marker.
interface imem_loader_if #(
  parameter int unsigned IW = loader_pkg::DEF_IW
) ();

  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/run_timer.sv
// Counts processor clock-enable cycles and flags the last one of a bounded run.
module run_timer
  import loader_pkg::*;
#(
  parameter int unsigned W = RUN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] len,
  input  logic         enable,
  output logic         tc_c,
  output logic         unlimited_c
);

  logic [W-1:0] len_q, len_d;
  logic [W-1:0] cnt_q, cnt_d;

  // Latch the run length and clear the count on load; count while enabled.
  always_comb begin
    len_d = len_q;
    cnt_d = cnt_q;
    if (load) begin
      len_d = len;
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

  // A zero length means the run is open-ended; tc then has no meaning.
  assign unlimited_c = (len_q == '0);
  assign tc_c        = enable && (cnt_q == (len_q - W'(1)));

endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction memory, then runs the processor for a bounded time.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned IW    = DEF_IW,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [RUN_W-1:0] run_len,
  input  logic             stop,
  imem_loader_if.slave     up,
  output logic             imem_we,
  output logic [AW-1:0]    imem_addr,
  output logic [IW-1:0]    imem_wdata,
  output logic             proc_hold,
  output logic             ce,
  output logic             busy,
  output logic             done,
  output logic             err_trunc,
  output logic [AW:0]      words_loaded
);

  localparam int unsigned WL_W = AW + 1;

  state_e state_q, state_d;

  logic in_ready_q, in_ready_d;
  logic ce_q, ce_d;
  logic proc_hold_q, proc_hold_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic            imem_we_q, imem_we_d;
  logic [AW-1:0]   imem_addr_q, imem_addr_d;
  logic [IW-1:0]   imem_wdata_q, imem_wdata_d;
  logic            err_trunc_q, err_trunc_d;
  logic [WL_W-1:0] words_loaded_q, words_loaded_d;

  logic accept_c;
  logic last_idx_c;
  logic start_ok_c;
  logic tc_c;
  logic unlimited_c;
  logic run_end_c;

  // in_ready is only ever high in LOAD, so it alone qualifies the handshake.
  assign accept_c   = up.in_valid && in_ready_q;
  assign last_idx_c = (words_loaded_q == WL_W'(DEPTH - 1));
  assign start_ok_c = start && ((state_q == ST_IDLE) || (state_q == ST_HALT));
  assign run_end_c  = stop || (tc_c && !unlimited_c);

  run_timer #(.W(RUN_W)) u_run_timer (
    .clk         (clk),
    .reset       (reset),
    .load        (start_ok_c),
    .len         (run_len),
    .enable      (ce_q),
    .tc_c        (tc_c),
    .unlimited_c (unlimited_c)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; in RUN a simultaneous start is ignored so stop wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: if (accept_c && (up.in_last || last_idx_c)) state_d = ST_RUN;
      ST_RUN:  if (run_end_c) state_d = ST_HALT;
      ST_HALT: if (start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs, computed from the next state so the flops track the FSM.
  always_comb begin
    in_ready_d  = 1'b0;
    ce_d        = 1'b0;
    proc_hold_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      ST_IDLE: proc_hold_d = 1'b1;
      ST_LOAD: begin
        in_ready_d  = 1'b1;
        proc_hold_d = 1'b1;
        busy_d      = 1'b1;
      end
      ST_RUN: begin
        ce_d   = 1'b1;
        busy_d = 1'b1;
      end
      ST_HALT: done_d = 1'b1;
      default: proc_hold_d = 1'b1;
    endcase
  end

  // Memory write, word count and truncation flag.
  always_comb begin
    imem_we_d      = accept_c;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    words_loaded_d = words_loaded_q;
    err_trunc_d    = err_trunc_q;
    if (accept_c) begin
      imem_addr_d  = words_loaded_q[AW-1:0];
      imem_wdata_d = up.in_data;
      if (words_loaded_q != WL_W'(DEPTH)) begin
        words_loaded_d = words_loaded_q + WL_W'(1);
      end
      if (last_idx_c && !up.in_last) begin
        err_trunc_d = 1'b1;
      end
    end
    if (start_ok_c) begin
      words_loaded_d = '0;
      err_trunc_d    = 1'b0;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_q     <= 1'b0;
      ce_q           <= 1'b0;
      proc_hold_q    <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      err_trunc_q    <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      in_ready_q     <= in_ready_d;
      ce_q           <= ce_d;
      proc_hold_q    <= proc_hold_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      err_trunc_q    <= err_trunc_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign up.in_ready    = in_ready_q;
  assign imem_we        = imem_we_q;
  assign imem_addr      = imem_addr_q;
  assign imem_wdata     = imem_wdata_q;
  assign proc_hold      = proc_hold_q;
  assign ce             = ce_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_trunc      = err_trunc_q;
  assign words_loaded   = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: vector table of load/run scenarios plus hand-written corner sequences.
module tb_imem_loader;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned IW    = 13;
  localparam int unsigned AW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    run_len;
  logic          stop;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic          proc_hold;
  logic          ce;
  logic          busy;
  logic          done;
  logic          err_trunc;
  logic [AW:0]   words_loaded;

  imem_loader_if #(.IW(IW)) up ();

  imem_loader #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .run_len      (run_len),
    .stop         (stop),
    .up           (up),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .proc_hold    (proc_hold),
    .ce           (ce),
    .busy         (busy),
    .done         (done),
    .err_trunc    (err_trunc),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
    int            cyc;
  } wr_t;

  wr_t wr_q[$];
  int  sb_addr = 0;

  typedef struct {
    int run_len;
    int nwords;
    bit has_last;
    bit gap;
    bit junk;
    int exp_words;
    bit exp_trunc;
    int exp_ce;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: a handshake queues the expected write, the registered write pops it.
  always @(negedge clk) begin
    wr_t e;
    if (reset) begin
      if (imem_we) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", imem_addr, imem_wdata);
        end else begin
          e = wr_q.pop_front();
          chk("wr_addr", 32'(imem_addr), 32'(e.addr));
          chk("wr_data", 32'(imem_wdata), 32'(e.data));
          chk("wr_latency", 32'(cyc), 32'(e.cyc + 1));
        end
      end
      if (up.in_valid && up.in_ready) begin
        e.addr = AW'(sb_addr);
        e.data = up.in_data;
        e.cyc  = cyc;
        wr_q.push_back(e);
        sb_addr++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input int len);
    sb_addr = 0;
    start   = 1'b1;
    run_len = 8'(len);
    step();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [IW-1:0] d, input logic l);
    int n  = 0;
    bit ok = 1'b0;
    up.in_valid = 1'b1;
    up.in_data  = d;
    up.in_last  = l;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = up.in_ready;
      step();
      n++;
    end
    up.in_valid = 1'b0;
    up.in_last  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no handshake in 20 cycles expected in_ready");
    end
  endtask

  function automatic logic [IW-1:0] word_of(input int v, input int i);
    if (v == 0) begin
      case (i)
        0:       return 13'h0A1;
        1:       return 13'h1B2;
        default: return 13'h1FFF;
      endcase
    end
    return 13'((v * 997 + i * 131) ^ 'h0A5A);
  endfunction

  // Counts ce-high samples until done (bounded); optionally drives start/stop at a given count.
  task automatic run_until_done(input int stop_at, input bit with_start, output int cnt);
    bit fin = 1'b0;
    cnt = 0;
    for (int n = 0; n < 400 && !fin; n++) begin
      @(negedge clk);
      if (ce) cnt++;
      if (done) begin
        fin   = 1'b1;
        stop  = 1'b0;
        start = 1'b0;
      end else if (stop_at > 0 && cnt == stop_at) begin
        stop = 1'b1;
        if (with_start) start = 1'b1;
      end
    end
    stop  = 1'b0;
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(up.in_ready), 0);
    chk({tag, "_imem_we"}, 32'(imem_we), 0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 0);
    chk({tag, "_imem_wdata"}, 32'(imem_wdata), 0);
    chk({tag, "_proc_hold"}, 32'(proc_hold), 1);
    chk({tag, "_ce"}, 32'(ce), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err_trunc"}, 32'(err_trunc), 0);
    chk({tag, "_words_loaded"}, 32'(words_loaded), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int cnt;
    int we_cnt;

    //            len  nw  last  gap   junk  words trunc ce
    vecs[0] = '{  4,   3, 1'b1, 1'b0, 1'b0,   3, 1'b0,   4};
    vecs[1] = '{  6,  32, 1'b0, 1'b0, 1'b1,  32, 1'b1,   6};
    vecs[2] = '{  1,   5, 1'b1, 1'b1, 1'b0,   5, 1'b0,   1};
    vecs[3] = '{255,   1, 1'b1, 1'b0, 1'b0,   1, 1'b0, 255};

    reset       = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    run_len     = '0;
    up.in_valid = 1'b0;
    up.in_data  = '0;
    up.in_last  = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    step();
    reset = 1'b1;
    step();

    for (int v = 0; v < 4; v++) begin
      start_pulse(vecs[v].run_len);
      @(negedge clk);
      chk("load_in_ready", 32'(up.in_ready), 1);
      chk("load_busy", 32'(busy), 1);
      chk("load_proc_hold", 32'(proc_hold), 1);
      chk("load_words_clr", 32'(words_loaded), 0);
      chk("load_trunc_clr", 32'(err_trunc), 0);
      step();
      for (int i = 0; i < vecs[v].nwords; i++) begin
        if (vecs[v].gap && i > 0) step();
        send_word(word_of(v, i), vecs[v].has_last && (i == vecs[v].nwords - 1));
      end
      @(negedge clk);
      chk("run_in_ready", 32'(up.in_ready), 0);
      chk("run_ce", 32'(ce), 1);
      chk("run_proc_hold", 32'(proc_hold), 0);
      chk("run_words", 32'(words_loaded), 32'(vecs[v].exp_words));
      chk("run_trunc", 32'(err_trunc), 32'(vecs[v].exp_trunc));
      up.in_valid = vecs[v].junk;
      up.in_data  = 13'h1555;
      cnt = 1;
      run_until_done(0, 1'b0, we_cnt);
      cnt = cnt + we_cnt;
      chk("ce_cycles", 32'(cnt), 32'(vecs[v].exp_ce));
      chk("halt_done", 32'(done), 1);
      chk("halt_ce", 32'(ce), 0);
      chk("halt_busy", 32'(busy), 0);
      chk("halt_proc_hold", 32'(proc_hold), 0);
      repeat (3) @(negedge clk);
      up.in_valid = 1'b0;
      chk("halt_words_kept", 32'(words_loaded), 32'(vecs[v].exp_words));
      chk("halt_trunc_kept", 32'(err_trunc), 32'(vecs[v].exp_trunc));
      chk("sb_drained", 32'(wr_q.size()), 0);
      step();
    end

    // Unlimited run ended by stop after 10 ce cycles; start ignored while loading.
    start_pulse(0);
    send_word(13'h0123, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("ign_start_words", 32'(words_loaded), 1);
    chk("ign_start_ready", 32'(up.in_ready), 1);
    step();
    send_word(13'h0456, 1'b1);
    run_until_done(10, 1'b0, cnt);
    chk("stop_ce_cycles", 32'(cnt), 10);
    chk("stop_done", 32'(done), 1);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    @(negedge clk);
    chk("halt_ign_stop", 32'(done), 1);
    step();

    // start and stop together in RUN: stop must win.
    start_pulse(0);
    send_word(13'h0789, 1'b1);
    run_until_done(3, 1'b1, cnt);
    chk("ss_ce_cycles", 32'(cnt), 3);
    chk("ss_done", 32'(done), 1);
    chk("ss_in_ready", 32'(up.in_ready), 0);
    chk("ss_busy", 32'(busy), 0);
    step();

    // Reset after the second word of a load: immediate reset values, no trailing write.
    start_pulse(7);
    send_word(13'h0AAA, 1'b0);
    send_word(13'h0BBB, 1'b0);
    reset = 1'b0;
    wr_q.delete();
    sb_addr = 0;
    #1;
    chk_reset_outputs("midrst");
    step();
    step();
    reset = 1'b1;
    up.in_valid = 1'b1;
    up.in_data  = 13'h0CCC;
    we_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (imem_we) we_cnt++;
    end
    up.in_valid = 1'b0;
    chk("post_rst_writes", 32'(we_cnt), 0);
    chk("post_rst_words", 32'(words_loaded), 0);
    chk("post_rst_hold", 32'(proc_hold), 1);
    step();
    start_pulse(3);
    send_word(13'h0DDD, 1'b0);
    send_word(13'h0EEE, 1'b1);
    @(negedge clk);
    chk("reload_words", 32'(words_loaded), 2);
    run_until_done(0, 1'b0, cnt);
    chk("reload_ce_cycles", 32'(cnt + 1), 3);
    chk("reload_done", 32'(done), 1);
    chk("final_sb_drained", 32'(wr_q.size()), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
